// File: rtl/alu_pkg.sv
// Shared ALU opcodes, multiply/divide mode encodings and sequencer state type.
// Combinational definitions only; no latency or flow control.
package alu_pkg;

    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0010;
    localparam logic [3:0] ALU_OP_ADD = 4'b0100;
    localparam logic [3:0] ALU_OP_SUB = 4'b1100;
    localparam logic [3:0] ALU_OP_SLT = 4'b0001;

    localparam logic MD_MODE_MUL = 1'b0;
    localparam logic MD_MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Sequential 16x16 unsigned multiply / 16/16 restoring divide driving a shared ALU.
// Latency 17 cycles accept-to-Done (1 cycle for divide by zero); Start ignored while busy (Ready=0).
module alu_muldiv_seq
    import alu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Mode,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    output logic        Ready,
    output logic        Done,
    output logic [15:0] ResHi,
    output logic [15:0] ResLo,
    output logic        DivZero,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic        AluAInvert,
    output logic [3:0]  AluOp,
    input  logic [15:0] AluResult,
    input  logic        AluCarryOut
);

    md_state_t   state, state_nxt;
    logic [3:0]  cnt;
    logic [15:0] hi, lo, d;
    logic [15:0] hi_nxt, lo_nxt;
    logic        mode_q;
    logic        accept;
    logic        start_div_zero;
    logic [15:0] div_s;

    assign accept         = Start && (state != ITER);
    assign start_div_zero = (Mode == MD_MODE_DIV) && (Y == 16'd0);
    assign div_s          = {hi[14:0], lo[15]};
    assign AluAInvert     = 1'b0;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Ready     = 1'b1;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = start_div_zero ? DONE : ITER;
            end
            ITER: begin
                Ready = 1'b0;
                if (cnt == 4'd15) state_nxt = DONE;
            end
            DONE: begin
                Done = 1'b1;
                if (accept) state_nxt = start_div_zero ? DONE : ITER;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand mux kept apart from the result update so the ALU round trip is not a false loop.
    always_comb begin
        AluA  = 16'd0;
        AluB  = 16'd0;
        AluOp = ALU_OP_ADD;
        if (state == ITER) begin
            AluB = d;
            if (mode_q == MD_MODE_MUL) begin
                AluA = hi;
            end else begin
                AluA  = div_s;
                AluOp = ALU_OP_SUB;
            end
        end
    end

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (mode_q == MD_MODE_MUL) begin
            if (lo[0]) {hi_nxt, lo_nxt} = {AluCarryOut, AluResult, lo[15:1]};
            else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[15:1]};
        end else begin
            // Hi[15] set means the shifted partial remainder exceeds 16 bits, so it always covers D.
            if (hi[15] || AluCarryOut) begin
                hi_nxt = AluResult;
                lo_nxt = {lo[14:0], 1'b1};
            end else begin
                hi_nxt = div_s;
                lo_nxt = {lo[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hi      <= 16'd0;
            lo      <= 16'd0;
            d       <= 16'd0;
            cnt     <= 4'd0;
            mode_q  <= MD_MODE_MUL;
            ResHi   <= 16'd0;
            ResLo   <= 16'd0;
            DivZero <= 1'b0;
        end else if (accept) begin
            hi      <= 16'd0;
            lo      <= (Mode == MD_MODE_DIV) ? X : Y;
            d       <= (Mode == MD_MODE_DIV) ? Y : X;
            cnt     <= 4'd0;
            mode_q  <= Mode;
            DivZero <= 1'b0;
            if (start_div_zero) begin
                ResHi   <= X;
                ResLo   <= 16'hFFFF;
                DivZero <= 1'b1;
            end
        end else if (state == ITER) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
                ResHi <= hi_nxt;
                ResLo <= lo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized scoreboard bench for alu_muldiv_seq with a behavioural 16-bit ALU alongside.
module tb_alu_muldiv_seq;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Mode  = 1'b0;
    logic [15:0] X = 16'd0;
    logic [15:0] Y = 16'd0;
    logic        Ready, Done, DivZero, AluAInvert, AluCarryOut;
    logic [15:0] ResHi, ResLo, AluA, AluB, AluResult;
    logic [3:0]  AluOp;

    alu_muldiv_seq dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .X(X), .Y(Y),
        .Ready(Ready), .Done(Done), .ResHi(ResHi), .ResLo(ResLo), .DivZero(DivZero),
        .AluA(AluA), .AluB(AluB), .AluAInvert(AluAInvert), .AluOp(AluOp),
        .AluResult(AluResult), .AluCarryOut(AluCarryOut)
    );

    always #5 Clock = ~Clock;

    // Shared ALU: AluOp[3] inverts B with carry-in 1, giving A-B with carry meaning no borrow.
    logic [15:0] alu_a_eff, alu_b_eff;
    logic [16:0] alu_sum;
    always_comb begin
        alu_a_eff   = AluAInvert ? ~AluA : AluA;
        alu_b_eff   = AluOp[3] ? ~AluB : AluB;
        alu_sum     = {1'b0, alu_a_eff} + {1'b0, alu_b_eff} + {16'd0, AluOp[3]};
        AluCarryOut = alu_sum[16];
        case (AluOp[2:0])
            3'b000:  AluResult = alu_a_eff & alu_b_eff;
            3'b010:  AluResult = alu_a_eff | alu_b_eff;
            3'b001:  AluResult = {15'd0, alu_sum[15]};
            default: AluResult = alu_sum[15:0];
        endcase
    end

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [15:0] held_hi = 16'd0;
    logic [15:0] held_lo = 16'd0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},   {31'd0, Ready},      32'd1);
        chk({tag, "_done"},    {31'd0, Done},       32'd0);
        chk({tag, "_reshi"},   {16'd0, ResHi},      32'd0);
        chk({tag, "_reslo"},   {16'd0, ResLo},      32'd0);
        chk({tag, "_divzero"}, {31'd0, DivZero},    32'd0);
        chk({tag, "_alua"},    {16'd0, AluA},       32'd0);
        chk({tag, "_alub"},    {16'd0, AluB},       32'd0);
        chk({tag, "_aluop"},   {28'd0, AluOp},      32'd4);
        chk({tag, "_ainv"},    {31'd0, AluAInvert}, 32'd0);
    endtask

    // Reference result straight from integer arithmetic.
    function automatic exp_t model(input logic m, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        logic [31:0] p;
        e.acc_cyc = 0;
        e.dz      = 1'b0;
        e.lat     = 17;
        if (m == 1'b0) begin
            p    = {16'd0, x} * {16'd0, y};
            e.hi = p[31:16];
            e.lo = p[15:0];
        end else if (y == 16'd0) begin
            e.hi  = x;
            e.lo  = 16'hFFFF;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
        end
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (Ready !== 1'b1 && n < 100) begin
            @(posedge Clock); #1;
            n++;
        end
        if (Ready !== 1'b1) chk("ready_timeout", {31'd0, Ready}, 32'd1);
    endtask

    task automatic issue(input logic m, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        wait_ready();
        Start = 1'b1; Mode = m; X = x; Y = y;
        e = model(m, x, y);
        @(posedge Clock); #1;
        Start = 1'b0;
        e.acc_cyc = cyc;
        expq.push_back(e);
    endtask

    // Monitor: compares every Done against the oldest outstanding expectation.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset) begin
            held_hi = 16'd0;
            held_lo = 16'd0;
        end else if (Done === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_done", {31'd0, Done}, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("res_hi",  {16'd0, ResHi},   {16'd0, e.hi});
                chk("res_lo",  {16'd0, ResLo},   {16'd0, e.lo});
                chk("divzero", {31'd0, DivZero}, {31'd0, e.dz});
                chk("latency", cyc - e.acc_cyc + 1, e.lat);
                chk("ready_in_done", {31'd0, Ready}, 32'd1);
                held_hi = e.hi;
                held_lo = e.lo;
            end
        end else begin
            chk("held_hi", {16'd0, ResHi}, {16'd0, held_hi});
            chk("held_lo", {16'd0, ResLo}, {16'd0, held_lo});
        end
    end

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        chk_reset_vals("rst");
        Reset = 1'b0;
        @(posedge Clock); #1;

        issue(1'b0, 16'd13, 16'd11);
        issue(1'b0, 16'hFFFF, 16'hFFFF);
        issue(1'b1, 16'd100, 16'd7);
        issue(1'b1, 16'hFFFF, 16'hFFFF);
        issue(1'b1, 16'd1234, 16'd0);
        issue(1'b1, 16'd55, 16'd0);
        issue(1'b0, 16'd0, 16'h8001);

        // A Start with different operands while busy must be dropped.
        issue(1'b1, 16'd50000, 16'd333);
        repeat (5) @(posedge Clock);
        #1;
        chk("ready_busy", {31'd0, Ready}, 32'd0);
        chk("alu_sub_in_div", {28'd0, AluOp}, 32'd12);
        Start = 1'b1; Mode = 1'b0; X = 16'd9; Y = 16'd9;
        @(posedge Clock); #1;
        Start = 1'b0;

        for (int i = 0; i < 30; i++) begin
            logic        m;
            logic [15:0] x, y;
            m = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            y = 16'($urandom);
            case ($urandom_range(0, 7))
                0: y = 16'd0;
                1: x = 16'hFFFF;
                2: y = 16'($urandom_range(1, 3));
                default: ;
            endcase
            issue(m, x, y);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge Clock);
            #0;
        end
        wait_ready();
        @(posedge Clock); #1;

        // Abort in the middle of an operation.
        issue(1'b0, 16'd777, 16'd999);
        repeat (7) @(posedge Clock);
        #1;
        Reset = 1'b1;
        expq.delete();
        @(posedge Clock); #1;
        chk_reset_vals("abort");
        Reset = 1'b0;
        repeat (25) @(posedge Clock);
        #1;
        chk("abort_idle_ready", {31'd0, Ready}, 32'd1);

        issue(1'b0, 16'd3, 16'd5);

        for (int n = 0; n < 200 && expq.size() != 0; n++) @(posedge Clock);
        repeat (2) @(posedge Clock);
        #1;
        chk("queue_drained", expq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
